// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin sharing of one pipelined divider among NREQ
// requesters. A tag pipe matched to the divider latency carries the requester
// id and divide-by-zero flag so each result returns to the requester that issued it.
module div_share_arbiter #(
  parameter  int DIVIDEND = 4,
  parameter  int DIVISOR  = 2,
  parameter  int NREQ     = 4,
  parameter  int LATENCY  = 4,
  localparam int IDW      = $clog2(NREQ),
  localparam int CW       = $clog2(LATENCY + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*DIVIDEND-1:0]   req_dividend,
  input  logic [NREQ*DIVISOR-1:0]    req_divisor,
  output logic [DIVIDEND-1:0]        div_dividend,
  output logic [DIVISOR-1:0]         div_divisor,
  input  logic [DIVIDEND-1:0]        div_quotient,
  input  logic [DIVISOR-1:0]         div_remainder,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [DIVIDEND-1:0]        rsp_quotient,
  output logic [DIVISOR-1:0]         rsp_remainder,
  output logic                       rsp_dbz,
  output logic [CW-1:0]              inflight
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic           dbz;
  } tag_t;

  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  tag_t [LATENCY-1:0]   tag_q;
  logic                 found;
  logic [IDW-1:0]       winner;
  logic                 hs;
  logic                 op_dbz;

  // Round-robin scan starting at ptr_q; first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Grant only out of reset and when enabled; grant implies valid, so ready is the handshake.
  assign hs        = reset_n & enable & found;
  assign req_ready = hs ? (NREQ'(1) << winner) : '0;

  // Operand mux; idle cycles present 0/1 so the divider never sees a zero divisor.
  always_comb begin
    div_dividend = '0;
    div_divisor  = DIVISOR'(1);
    op_dbz       = 1'b0;
    if (hs) begin
      div_dividend = req_dividend[winner*DIVIDEND +: DIVIDEND];
      div_divisor  = req_divisor[winner*DIVISOR +: DIVISOR];
      op_dbz       = (req_divisor[winner*DIVISOR +: DIVISOR] == '0);
    end
  end

  // Pointer advances past the winner on each handshake.
  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
  end

  // In-flight count: issue adds, result strobe retires; both together cancel.
  always_comb begin
    inflight_d = inflight_q;
    case ({hs, rsp_valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Pointer and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Tag pipe shifts every clock in lockstep with the divider (no stall path).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= {hs, winner, op_dbz};
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rsp_valid     = tag_q[LATENCY-1].vld;
  assign rsp_id        = tag_q[LATENCY-1].id;
  assign rsp_dbz       = tag_q[LATENCY-1].dbz;
  assign rsp_quotient  = tag_q[LATENCY-1].dbz ? '1 : div_quotient;
  assign rsp_remainder = tag_q[LATENCY-1].dbz ? '0 : div_remainder;
  assign inflight      = inflight_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Randomized + directed bench for div_share_arbiter with a pipelined divider model
// and a queue-based scoreboard of expected responses.
module tb_div_share_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 4;

  logic        clock, reset_n, enable;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_dividend;
  logic [7:0]  req_divisor;
  logic [3:0]  div_dividend, div_quotient, rsp_quotient;
  logic [1:0]  div_divisor, div_remainder, rsp_remainder;
  logic        rsp_valid, rsp_dbz;
  logic [1:0]  rsp_id;
  logic [2:0]  inflight;

  div_share_arbiter #(.DIVIDEND(4), .DIVISOR(2), .NREQ(NREQ), .LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz), .inflight(inflight)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bench-side operands, packed onto the DUT buses.
  logic [3:0] av [NREQ];
  logic [1:0] bv [NREQ];
  always_comb begin
    req_dividend = '0;
    req_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*4 +: 4] = av[i];
      req_divisor[i*2 +: 2]  = bv[i];
    end
  end

  // Pipelined divider model: samples at the edge, result LAT-1 edges later.
  // A zero divisor yields arbitrary garbage the arbiter must override.
  logic [3:0] pa [LAT];
  logic [1:0] pb [LAT];
  always @(posedge clock) begin
    pa[0] <= div_dividend;
    pb[0] <= div_divisor;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  always_comb begin
    div_quotient  = 4'hA;
    div_remainder = 2'h3;
    if (pb[LAT-1] != 2'd0) begin
      div_quotient  = pa[LAT-1] / {2'b00, pb[LAT-1]};
      div_remainder = 2'(pa[LAT-1] % {2'b00, pb[LAT-1]});
    end
  end

  typedef struct { int due; int id; logic [3:0] a; logic [1:0] b; } exp_t;
  typedef struct { logic [3:0] a; logic [1:0] b; } op_t;

  exp_t sb [$];
  op_t  pool [NREQ][$];
  int   gq [$];
  int   checks = 0, errors = 0;
  int   ecount = 0, ptr = 0, lw = -1, peak = 0, rsp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  // Reference model evaluated once per cycle, between clock edges.
  task automatic check_cycle();
    int   w;
    exp_t e;
    logic [3:0] er;
    logic [3:0] eq;
    logic [1:0] erm;
    w = -1;
    if (reset_n && enable)
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr + k) % NREQ;
        if (w < 0 && req_valid[i]) w = i;
      end
    er = (w >= 0) ? 4'(1 << w) : 4'h0;
    chk("grant", req_ready, er);
    chk("inflight", inflight, sb.size());
    if (int'(inflight) > peak) peak = int'(inflight);
    if (w >= 0) begin
      chk("div_a", div_dividend, av[w]);
      chk("div_b", div_divisor, bv[w]);
    end else begin
      chk("idle_a", div_dividend, 0);
      chk("idle_b", div_divisor, 1);
    end
    if (sb.size() > 0 && sb[0].due == ecount) begin
      e = sb.pop_front();
      rsp_cnt++;
      eq  = (e.b == 0) ? 4'd15 : e.a / {2'b00, e.b};
      erm = (e.b == 0) ? 2'd0  : 2'(e.a % {2'b00, e.b});
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_dbz", rsp_dbz, (e.b == 0));
      chk("rsp_q", rsp_quotient, eq);
      chk("rsp_r", rsp_remainder, erm);
    end else begin
      chk("rsp_idle", rsp_valid, 0);
    end
    lw = w;
    if (w >= 0) begin
      sb.push_back('{due: ecount + LAT, id: w, a: av[w], b: bv[w]});
      ptr = (w + 1) % NREQ;
      gq.push_back(w);
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    ecount++;
    #1;
  endtask

  // Reset discards in-flight ops; any randomized ops among them go back to their pool.
  task automatic do_reset(input int n);
    exp_t e;
    reset_n = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      pool[e.id].push_back('{a: e.a, b: e.b});
    end
    ptr = 0;
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, issued, base;
    logic did_rst;
    reset_n   = 1'b1;
    enable    = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) begin av[i] = 4'd0; bv[i] = 2'd1; end
    #1;
    // 1: reset with all requesters valid
    do_reset(3);
    req_valid = 4'h0;

    // 2: single 13/3 from requester 0
    av[0] = 4'd13; bv[0] = 2'd3; req_valid = 4'b0001;
    step();
    chk("t2_grant", lw, 0);
    req_valid = 4'h0;
    drain();

    // 3: all valid for 8 cycles from ptr=0
    do_reset(1);
    for (int i = 0; i < NREQ; i++) begin av[i] = 4'(i + 8); bv[i] = 2'(i); end
    gq.delete(); peak = 0; req_valid = 4'hF;
    repeat (8) step();
    req_valid = 4'h0;
    drain();
    chk("t3_count", gq.size(), 8);
    for (int k = 0; k < 8 && k < gq.size(); k++) chk("t3_order", gq[k], k % 4);
    chk("t3_peak", peak, 4);

    // 4: only 1 and 3 valid, ptr=0
    do_reset(1);
    gq.delete(); req_valid = 4'b1010;
    repeat (4) step();
    req_valid = 4'h0;
    drain();
    chk("t4_count", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++) chk("t4_order", gq[k], (k % 2) ? 3 : 1);

    // 5: divide by zero then normal op on requester 2
    av[2] = 4'd9; bv[2] = 2'd0; req_valid = 4'b0100;
    step();
    chk("t5_grant0", lw, 2);
    bv[2] = 2'd2;
    step();
    chk("t5_grant1", lw, 2);
    req_valid = 4'h0;
    drain();

    // 6: exhaustive operand pairs, random valid/enable, one mid-run reset
    for (int p = 0; p < 64; p++) pool[p % NREQ].push_back('{a: 4'(p), b: 2'(p >> 4)});
    cyc = 0; issued = 0; did_rst = 1'b0; base = rsp_cnt;
    while ((pool[0].size() + pool[1].size() + pool[2].size() + pool[3].size() + sb.size()) > 0
           && cyc < 3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pool[i].size() > 0 && $urandom_range(0, 3) != 0) begin
          req_valid[i] = 1'b1;
          av[i] = pool[i][0].a;
          bv[i] = pool[i][0].b;
        end else begin
          req_valid[i] = 1'b0;
          av[i] = 4'($urandom);
          bv[i] = 2'($urandom);
        end
      end
      enable = ($urandom_range(0, 3) != 0);
      step();
      if (lw >= 0) begin
        void'(pool[lw].pop_front());
        issued++;
      end
      if (!did_rst && issued >= 30) begin
        did_rst = 1'b1;
        do_reset(2);
      end
      cyc++;
    end
    chk("t6_done", (cyc < 3000), 1);
    chk("t6_rsp_total", rsp_cnt - base, 64);
    req_valid = 4'h0;
    enable = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
